// File: rtl/cla_pkg.sv
// Shared types and helpers for the two-level carry-lookahead pipelined adder.
package cla_pkg;

  localparam int CLA_GROUP_MIN = 2;
  localparam int CLA_GROUP_MAX = 8;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int ngrp(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group_n.sv
// N-bit carry-lookahead cell: every carry and the group G/P are flat sum-of-products,
// so no carry ripples through another inside the cell.
module cla_group_n
  import cla_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] g,
  input  logic [N-1:0] p,
  input  logic         ci,
  output logic [N:1]   c,
  output logic         G,
  output logic         P
);

  // AND of v[lo..hi]; an empty span is 1.
  function automatic logic p_span(input logic [N-1:0] v, input int lo, input int hi);
    logic r;
    r = 1'b1;
    for (int k = 0; k < N; k++)
      if (k >= lo && k <= hi) r = r & v[k];
    return r;
  endfunction

  always_comb begin
    c = '0;
    G = 1'b0;
    for (int i = 0; i < N; i++) begin
      c[i+1] = ci & p_span(p, 0, i);
      for (int j = 0; j <= i; j++)
        c[i+1] = c[i+1] | (g[j] & p_span(p, j + 1, i));
    end
    for (int j = 0; j < N; j++)
      G = G | (g[j] & p_span(p, j + 1, N - 1));
  end

  assign P = &p;

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Optional overflow/zero flags are built when CLA_PIPE_FLAGS_EN is defined.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NGRP = ngrp(WIDTH, GROUP);

  if (GROUP < CLA_GROUP_MIN || GROUP > CLA_GROUP_MAX || (WIDTH % GROUP) != 0) begin : g_bad_cfg
    $error("cla_pipe_adder: GROUP must be 2..8 and divide WIDTH");
  end

  // ---------------- handshake ----------------
  logic s1_valid_q, s1_valid_d;
  logic out_valid_q, out_valid_d;
  logic s2_adv, s1_load, s2_load;

  assign s2_adv    = !out_valid_q | out_ready;
  assign in_ready  = !s1_valid_q | s2_adv;
  assign s1_load   = in_valid & in_ready;
  assign s2_load   = s2_adv & s1_valid_q;
  assign out_valid = out_valid_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (s2_adv)   out_valid_d = s1_valid_q;
    if (in_ready) s1_valid_d  = in_valid;
  end

  // ---------------- stage 1: bit and group generate/propagate ----------------
  logic [WIDTH-1:0]             bx, p_d, g_d;
  logic                         c0_d;
  logic [NGRP-1:0]              grp_g_d, grp_p_d;
  logic [NGRP-1:0][GROUP:1]     unused_s1_c;

  assign bx   = sub ? ~b : b;
  assign p_d  = a ^ bx;
  assign g_d  = a & bx;
  assign c0_d = sub | cin;

  for (genvar k = 0; k < NGRP; k++) begin : g_s1
    cla_group_n #(.N(GROUP)) u_cell (
      .g  (g_d[k*GROUP +: GROUP]),
      .p  (p_d[k*GROUP +: GROUP]),
      .ci (1'b0),
      .c  (unused_s1_c[k]),
      .G  (grp_g_d[k]),
      .P  (grp_p_d[k])
    );
  end

  logic [WIDTH-1:0]  p_q, g_q;
  logic              c0_q;
  gp_t  [NGRP-1:0]   grp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      c0_q       <= 1'b0;
      grp_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        p_q  <= p_d;
        g_q  <= g_d;
        c0_q <= c0_d;
        for (int k = 0; k < NGRP; k++) begin
          grp_q[k].g <= grp_g_d[k];
          grp_q[k].p <= grp_p_d[k];
        end
      end
    end
  end

  // ---------------- stage 2: group carries, in-cell carries, sum ----------------
  logic [NGRP-1:0]          grp_g_q, grp_p_q;
  logic [NGRP:1]            gc;
  logic [NGRP:0]            cg;
  logic [NGRP-1:0][GROUP:1] bc;
  logic [WIDTH-1:0]         cbit, sum_d;
  logic                     cout_d;
  logic                     unused_l2_g, unused_l2_p;
  logic [NGRP-1:0]          unused_s2_g, unused_s2_p, unused_bc_top;

  always_comb begin
    grp_g_q = '0;
    grp_p_q = '0;
    for (int k = 0; k < NGRP; k++) begin
      grp_g_q[k] = grp_q[k].g;
      grp_p_q[k] = grp_q[k].p;
    end
  end

  cla_group_n #(.N(NGRP)) u_level2 (
    .g  (grp_g_q),
    .p  (grp_p_q),
    .ci (c0_q),
    .c  (gc),
    .G  (unused_l2_g),
    .P  (unused_l2_p)
  );

  assign cg = {gc, c0_q};

  for (genvar k = 0; k < NGRP; k++) begin : g_s2
    cla_group_n #(.N(GROUP)) u_cell (
      .g  (g_q[k*GROUP +: GROUP]),
      .p  (p_q[k*GROUP +: GROUP]),
      .ci (cg[k]),
      .c  (bc[k]),
      .G  (unused_s2_g[k]),
      .P  (unused_s2_p[k])
    );
    // The cell's top carry duplicates the level-2 carry into the next group.
    assign cbit[k*GROUP +: GROUP] = {bc[k][GROUP-1:1], cg[k]};
    assign unused_bc_top[k]       = bc[k][GROUP];
  end

  assign sum_d  = p_q ^ cbit;
  assign cout_d = cg[NGRP];

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s2_load) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef CLA_PIPE_FLAGS_EN
  logic a_msb_q, b_msb_q, ovf_q, zero_q;
  logic ovf_d, zero_d;

  assign ovf_d  = (a_msb_q == b_msb_q) & (sum_d[WIDTH-1] != a_msb_q);
  assign zero_d = ~|sum_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      if (s1_load) begin
        a_msb_q <= a[WIDTH-1];
        b_msb_q <= bx[WIDTH-1];
      end
      if (s2_load) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboarded bench: WIDTH=32/GROUP=4 vector table and handshake corner cases,
// plus random streams on WIDTH=16/GROUP=8 and WIDTH=24/GROUP=3 instances.
module tb_cla_pipe_adder;

`ifdef CLA_PIPE_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst2;

  // 32/4 instance
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [31:0] a, b, sum;
  // 16/8 instance
  logic        h_in_valid, h_in_ready, h_cin, h_sub, h_out_valid, h_out_ready, h_cout, h_ovf, h_zero;
  logic [15:0] h_a, h_b, h_sum;
  // 24/3 instance
  logic        t_in_valid, t_in_ready, t_cin, t_sub, t_out_valid, t_out_ready, t_cout, t_ovf, t_zero;
  logic [23:0] t_a, t_b, t_sum;

  cla_pipe_adder #(.WIDTH(32), .GROUP(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero));

  cla_pipe_adder #(.WIDTH(16), .GROUP(8)) u_dut16 (
    .clk(clk), .rst(rst2), .in_valid(h_in_valid), .in_ready(h_in_ready), .a(h_a), .b(h_b),
    .cin(h_cin), .sub(h_sub), .out_valid(h_out_valid), .out_ready(h_out_ready), .sum(h_sum),
    .cout(h_cout), .ovf(h_ovf), .zero(h_zero));

  cla_pipe_adder #(.WIDTH(24), .GROUP(3)) u_dut24 (
    .clk(clk), .rst(rst2), .in_valid(t_in_valid), .in_ready(t_in_ready), .a(t_a), .b(t_b),
    .cin(t_cin), .sub(t_sub), .out_valid(t_out_valid), .out_ready(t_out_ready), .sum(t_sum),
    .cout(t_cout), .ovf(t_ovf), .zero(t_zero));

  int   n_cmp = 0, n_err = 0, n_out = 0, acc16 = 0, acc24 = 0;
  res_t q_main[$], q16[$], q24[$];
  res_t e_main, e16, e24, act16, act24;

  // Reference: plain integer arithmetic; overflow = true signed result out of range.
  function automatic res_t ref_model(input int w, input logic [31:0] ra, rb, input logic rcin, rsub);
    res_t   res;
    longint mask, half, ua, ub, r, sa, sb, sr;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(ra) & mask;
    ub   = longint'(rb) & mask;
    r    = rsub ? ua + ((~ub) & mask) + 1 : ua + ub + longint'(rcin);
    sa   = (ua >= half) ? ua - (half << 1) : ua;
    sb   = (ub >= half) ? ub - (half << 1) : ub;
    sr   = rsub ? sa - sb : sa + sb + longint'(rcin);
    res.sum  = 32'(r & mask);
    res.cout = r[w];
    res.ovf  = FLAGS && (sr >= half || sr < -half);
    res.zero = FLAGS && ((r & mask) == 0);
    return res;
  endfunction

  function automatic vec_t mkv(input logic [31:0] va, vb, input logic vcin, vsub,
                               input logic [31:0] es, input logic ec, eo, ez);
    vec_t v;
    v.a = va; v.b = vb; v.cin = vcin; v.sub = vsub;
    v.exp.sum = es; v.exp.cout = ec; v.exp.ovf = eo & FLAGS; v.exp.zero = ez & FLAGS;
    return v;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input vec_t v, output int waits);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1; waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    n_cmp++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL send_accept: in_ready stuck 0 for %0d cycles", waits);
    end else q_main.push_back(v.exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Main scoreboard: pop on every output transfer.
  always @(negedge clk) if (!rst && out_valid && out_ready) begin
    n_out++;
    n_cmp++;
    if (q_main.size() == 0) begin
      n_err++;
      $display("FAIL main_spurious: output %h with nothing expected", sum);
    end else begin
      e_main = q_main.pop_front();
      if ({sum, cout, ovf, zero} !== e_main) begin
        n_err++;
        $display("FAIL main_result: got %h/%b%b%b expected %h/%b%b%b", sum, cout, ovf, zero,
                 e_main.sum, e_main.cout, e_main.ovf, e_main.zero);
      end
    end
  end

  // Random-width scoreboards: push on accept, pop on output transfer.
  always @(negedge clk) if (!rst2) begin
    if (h_in_valid && h_in_ready) begin
      q16.push_back(ref_model(16, {16'h0, h_a}, {16'h0, h_b}, h_cin, h_sub));
      acc16++;
    end
    if (t_in_valid && t_in_ready) begin
      q24.push_back(ref_model(24, {8'h0, t_a}, {8'h0, t_b}, t_cin, t_sub));
      acc24++;
    end
    if (h_out_valid && h_out_ready) begin
      n_cmp++;
      act16 = {{16'h0, h_sum}, h_cout, h_ovf, h_zero};
      if (q16.size() == 0) begin
        n_err++; $display("FAIL w16_spurious: output %h", act16);
      end else begin
        e16 = q16.pop_front();
        if (act16 !== e16) begin
          n_err++; $display("FAIL w16_result: got %h expected %h", act16, e16);
        end
      end
    end
    if (t_out_valid && t_out_ready) begin
      n_cmp++;
      act24 = {{8'h0, t_sum}, t_cout, t_ovf, t_zero};
      if (q24.size() == 0) begin
        n_err++; $display("FAIL w24_spurious: output %h", act24);
      end else begin
        e24 = q24.pop_front();
        if (act24 !== e24) begin
          n_err++; $display("FAIL w24_result: got %h expected %h", act24, e24);
        end
      end
    end
  end

  vec_t tbl[12];
  int   w, stall, n0;

  initial begin
    tbl[0]  = mkv(32'hFFFF_FFFF, 32'h1,         0, 0, 32'h0,         1, 0, 1);
    tbl[1]  = mkv(32'h5,         32'h7,         0, 1, 32'hFFFF_FFFE, 0, 0, 0);
    tbl[2]  = mkv(32'h8000_0000, 32'h1,         0, 1, 32'h7FFF_FFFF, 1, 1, 0);
    tbl[3]  = mkv(32'h7FFF_FFFF, 32'h1,         0, 0, 32'h8000_0000, 0, 1, 0);
    tbl[4]  = mkv(32'h1234_5678, 32'h9ABC_DEF0, 1, 0, 32'hACF1_3569, 0, 0, 0);
    tbl[5]  = mkv(32'h7,         32'h7,         1, 1, 32'h0,         1, 0, 1);
    tbl[6]  = mkv(32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0,         1, 1, 1);
    tbl[7]  = mkv(32'h0,         32'h0,         1, 0, 32'h1,         0, 0, 0);
    tbl[8]  = mkv(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 1, 0, 0);
    tbl[9]  = mkv(32'h0,         32'h1,         0, 1, 32'hFFFF_FFFF, 0, 0, 0);
    tbl[10] = mkv(32'h0000_FFFF, 32'h1,         0, 0, 32'h0001_0000, 0, 0, 0);
    tbl[11] = mkv(32'h0,         32'h8000_0000, 0, 1, 32'h8000_0000, 0, 1, 0);

    rst = 1'b1; rst2 = 1'b1;
    in_valid = 0; out_ready = 1; a = '0; b = '0; cin = 0; sub = 0;
    h_in_valid = 0; h_out_ready = 1; h_a = '0; h_b = '0; h_cin = 0; h_sub = 0;
    t_in_valid = 0; t_out_ready = 1; t_a = '0; t_b = '0; t_cin = 0; t_sub = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, sum, cout, ovf, zero}, '0);
    check("reset_in_ready", in_ready, 1);
    rst = 1'b0; rst2 = 1'b0;
    @(posedge clk); #1;

    // Latency: accepted at edge N, out_valid after edge N+1.
    send(tbl[0], w);
    check("lat_after_N", out_valid, 0);
    @(posedge clk); #1;
    check("lat_after_N1", out_valid, 1);
    @(posedge clk); #1;

    // Back-to-back beats with downstream always ready.
    n0 = n_out; stall = 0;
    for (int i = 1; i < 12; i++) begin
      send(tbl[i], w);
      stall += w;
    end
    check("b2b_in_ready_stalls", stall, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    check("b2b_result_count", n_out - n0, 11);

    // Backpressure: two beats fill the pipe, the third waits; held output stays put.
    n0 = n_out;
    out_ready = 1'b0;
    send(tbl[1], w);
    send(tbl[2], w);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("full_in_ready", in_ready, 0);
      check("full_out_valid", out_valid, 1);
      check("full_sum_hold", sum, tbl[1].exp.sum);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(tbl[3], w);
    repeat (4) @(posedge clk);
    #1;
    check("bp_result_count", n_out - n0, 3);
    check("bp_queue_empty", q_main.size(), 0);

    // Reset with both stages full: in-flight beats vanish.
    out_ready = 1'b0;
    send(tbl[4], w);
    send(tbl[5], w);
    rst = 1'b1;
    q_main.delete();
    #1;
    check("rst_async_outputs", {out_valid, sum, cout, ovf, zero}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    n0 = n_out;
    repeat (4) @(posedge clk);
    #1;
    check("rst_no_spurious", n_out - n0, 0);
    send(tbl[6], w);
    repeat (3) @(posedge clk);
    #1;
    check("rst_post_beat_count", n_out - n0, 1);

    // Random streams on the other geometries with random backpressure.
    for (int cyc = 0; cyc < 30000 && (acc16 < 10000 || acc24 < 10000); cyc++) begin
      @(posedge clk); #1;
      h_in_valid  = (acc16 < 10000) && ($urandom_range(0, 3) != 0);
      h_a = 16'(rnd_op()); h_b = 16'(rnd_op());
      h_cin = 1'($urandom_range(0, 1)); h_sub = 1'($urandom_range(0, 1));
      h_out_ready = ($urandom_range(0, 3) != 0);
      t_in_valid  = (acc24 < 10000) && ($urandom_range(0, 3) != 0);
      t_a = 24'(rnd_op()); t_b = 24'(rnd_op());
      t_cin = 1'($urandom_range(0, 1)); t_sub = 1'($urandom_range(0, 1));
      t_out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    h_in_valid = 0; t_in_valid = 0; h_out_ready = 1; t_out_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    check("w16_beats_accepted", acc16 >= 10000, 1);
    check("w24_beats_accepted", acc24 >= 10000, 1);
    check("w16_queue_drained", q16.size(), 0);
    check("w24_queue_drained", q24.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
